// File: rtl/cam_pkg.sv
// Shared types and default geometry for the OV7670 frame-capture sequencer.
package cam_pkg;

    // Default frame geometry: QQVGA, one framebuffer word per written pixel
    localparam int H_PX_DEFAULT = 160;
    localparam int V_LN_DEFAULT = 120;
    localparam int FRAME_PX     = H_PX_DEFAULT * V_LN_DEFAULT;

    // Capture sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        CLOSE   = 2'd3
    } cap_state_t;

endpackage

// File: rtl/cam_capture_ctrl_edge_det.sv
// Registered edge detector: keeps the previous sample of a pclk-synchronous
// input and flags its rising and falling edges combinationally.
module edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    // Previous-cycle sample; reset value chosen so reset does not fake an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

    assign rise = ~q & d;
    assign fall = q & ~d;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms cam_read on request, opens it only on a
// clean VSYNC falling edge, counts pixels and lines of the frame and reports
// each closed frame as done (exact geometry) or erroneous.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_PX    = H_PX_DEFAULT,
    parameter int V_LN    = V_LN_DEFAULT,
    parameter int AW      = 15,
    parameter int TIMEOUT = 2000000
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          mode_cont,
    input  logic          vsync,
    input  logic          href,
    input  logic          px_wr,
    output logic          cap_en,
    output logic          cap_clr,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err,
    output logic [AW:0]   px_cnt,
    output logic [7:0]    line_cnt,
    output logic [7:0]    frame_cnt
);

    localparam int          TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0] PX_TARGET = (AW + 1)'(H_PX * V_LN);
    localparam logic [7:0]  LN_TARGET = 8'(V_LN);

    cap_state_t    state;
    logic          cont;
    logic          to_err;
    logic [TW-1:0] to_cnt;
    logic          vs_rise;
    logic          vs_fall;
    logic          hr_fall;

    // VSYNC idles high (blanking), so its history resets high
    edge_det #(.RST_VAL(1'b1)) u_vsync_edge (
        .clk  (pclk),
        .rst  (rst),
        .d    (vsync),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    // Only the end of each HREF pulse matters for line counting
    edge_det #(.RST_VAL(1'b0)) u_href_edge (
        .clk  (pclk),
        .rst  (rst),
        .d    (href),
        .rise (),
        .fall (hr_fall)
    );

    // Sequencer, counters and timeout with every output registered
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cont       <= 1'b0;
            to_err     <= 1'b0;
            to_cnt     <= '0;
            cap_en     <= 1'b0;
            cap_clr    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            px_cnt     <= '0;
            line_cnt   <= '0;
            frame_cnt  <= '0;
        end else begin
            cap_clr    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state   <= ARM;
                        cont    <= mode_cont;
                        cap_clr <= 1'b1;
                        busy    <= 1'b1;
                        to_cnt  <= '0;
                        to_err  <= 1'b0;
                    end
                end
                ARM: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vs_fall) begin
                        state    <= CAPTURE;
                        cap_en   <= 1'b1;
                        px_cnt   <= '0;
                        line_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state  <= CLOSE;
                        to_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (px_wr && (px_cnt != '1)) begin
                        px_cnt <= px_cnt + 1'b1;
                    end
                    if (hr_fall && (line_cnt != 8'hFF)) begin
                        line_cnt <= line_cnt + 8'd1;
                    end
                    // A stop lets the running frame finish but prevents re-arming
                    if (stop) begin
                        cont <= 1'b0;
                    end
                    if (vs_rise) begin
                        state  <= CLOSE;
                        cap_en <= 1'b0;
                    end
                end
                CLOSE: begin
                    if (!to_err && (px_cnt == PX_TARGET) && (line_cnt == LN_TARGET)) begin
                        frame_done <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    frame_cnt <= frame_cnt + 8'd1;
                    to_err    <= 1'b0;
                    to_cnt    <= '0;
                    if (cont) begin
                        state   <= ARM;
                        cap_clr <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl: a cycle-by-cycle vector table for
// the short handshakes plus hand-written full-frame sequences.
module tb_cam_capture_ctrl;

    localparam int H_PX = 160;
    localparam int V_LN = 120;

    logic        pclk;
    logic        rst;
    logic        start;
    logic        start_to;
    logic        stop;
    logic        mode_cont;
    logic        vsync;
    logic        href;
    logic        px_wr;

    logic        cap_en, cap_clr, busy, frame_done, frame_err;
    logic [15:0] px_cnt;
    logic [7:0]  line_cnt, frame_cnt;

    logic        cap_en_t, cap_clr_t, busy_t, frame_done_t, frame_err_t;
    logic [15:0] px_cnt_t;
    logic [7:0]  line_cnt_t, frame_cnt_t;

    int total;
    int bad;
    logic seen_cap, seen_done, seen_err, seen_cap_t;

    cam_capture_ctrl #(.H_PX(H_PX), .V_LN(V_LN), .AW(15), .TIMEOUT(2000000)) dut (
        .pclk(pclk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
        .vsync(vsync), .href(href), .px_wr(px_wr),
        .cap_en(cap_en), .cap_clr(cap_clr), .busy(busy),
        .frame_done(frame_done), .frame_err(frame_err),
        .px_cnt(px_cnt), .line_cnt(line_cnt), .frame_cnt(frame_cnt)
    );

    cam_capture_ctrl #(.H_PX(H_PX), .V_LN(V_LN), .AW(15), .TIMEOUT(100)) dut_to (
        .pclk(pclk), .rst(rst), .start(start_to), .stop(stop), .mode_cont(mode_cont),
        .vsync(vsync), .href(href), .px_wr(px_wr),
        .cap_en(cap_en_t), .cap_clr(cap_clr_t), .busy(busy_t),
        .frame_done(frame_done_t), .frame_err(frame_err_t),
        .px_cnt(px_cnt_t), .line_cnt(line_cnt_t), .frame_cnt(frame_cnt_t)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic st, sp, md, vs, hr, pw;
        logic cap, clr, bsy, dn, er;
        int   px, ln, fc;
    } vec_t;

    function automatic vec_t mk(logic st, logic sp, logic md, logic vs, logic hr, logic pw,
                                logic cap, logic clr, logic bsy, logic dn, logic er,
                                int px, int ln, int fc);
        vec_t v;
        v.st = st; v.sp = sp; v.md = md; v.vs = vs; v.hr = hr; v.pw = pw;
        v.cap = cap; v.clr = clr; v.bsy = bsy; v.dn = dn; v.er = er;
        v.px = px; v.ln = ln; v.fc = fc;
        return v;
    endfunction

    task automatic check_output(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one pclk cycle; outputs are then stable for sampling
    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
        if (cap_en)     seen_cap  = 1'b1;
        if (frame_done) seen_done = 1'b1;
        if (frame_err)  seen_err  = 1'b1;
        if (cap_en_t)   seen_cap_t = 1'b1;
    endtask

    task automatic apply_stimulus(vec_t v);
        start = v.st; stop = v.sp; mode_cont = v.md;
        vsync = v.vs; href = v.hr; px_wr = v.pw;
        tick();
    endtask

    task automatic do_reset();
        start = 0; start_to = 0; stop = 0; mode_cont = 0;
        vsync = 1; href = 0; px_wr = 0;
        rst = 0;
        repeat (2) tick();
        rst = 1;
        tick();
    endtask

    // n complete lines: H_PX strobes with HREF high, then one HREF-low cycle
    task automatic send_lines(int n);
        for (int l = 0; l < n; l++) begin
            href = 1; px_wr = 1;
            repeat (H_PX) tick();
            href = 0; px_wr = 0;
            tick();
        end
    endtask

    task automatic close_frame(string name, int exp_done, int exp_err);
        vsync = 1;
        tick();
        check_output({name, " cap_en after vs_rise"}, cap_en, 0);
        check_output({name, " no pulse yet"}, frame_done | frame_err, 0);
        tick();
        check_output({name, " frame_done"}, frame_done, exp_done);
        check_output({name, " frame_err"}, frame_err, exp_err);
    endtask

    vec_t vecs[14];

    initial begin
        int n;
        total = 0; bad = 0;
        seen_cap = 0; seen_done = 0; seen_err = 0; seen_cap_t = 0;

        // ---------------- reset state ----------------
        do_reset();
        check_output("rst cap_en", cap_en, 0);
        check_output("rst cap_clr", cap_clr, 0);
        check_output("rst busy", busy, 0);
        check_output("rst done", frame_done, 0);
        check_output("rst err", frame_err, 0);
        check_output("rst px_cnt", px_cnt, 0);
        check_output("rst line_cnt", line_cnt, 0);
        check_output("rst frame_cnt", frame_cnt, 0);

        // ---------------- vector table ----------------
        //                st sp md vs hr pw  cap clr bsy dn er  px ln fc
        vecs[0]  = mk(1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0,  0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 1, 0, 0,  0, 0, 1, 0, 0,  0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0,  0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 0,  0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0,  1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0,  2, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0,  2, 1, 0);
        vecs[10] = mk(1, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0,  3, 1, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 1,  0, 0, 1, 0, 0,  4, 2, 0);
        vecs[12] = mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1,  4, 2, 1);
        vecs[13] = mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0,  4, 2, 1);
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d cap_en", i), cap_en, vecs[i].cap);
            check_output($sformatf("vec%0d cap_clr", i), cap_clr, vecs[i].clr);
            check_output($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
            check_output($sformatf("vec%0d done", i), frame_done, vecs[i].dn);
            check_output($sformatf("vec%0d err", i), frame_err, vecs[i].er);
            check_output($sformatf("vec%0d px_cnt", i), px_cnt, vecs[i].px);
            check_output($sformatf("vec%0d line_cnt", i), line_cnt, vecs[i].ln);
            check_output($sformatf("vec%0d frame_cnt", i), frame_cnt, vecs[i].fc);
        end
        start = 0; stop = 0; px_wr = 0; href = 0; vsync = 1;

        // ---------------- mid-frame start, then single-shot full frame ----------------
        do_reset();
        vsync = 0; tick();
        send_lines(5);
        start = 1; tick(); start = 0;
        check_output("mid busy", busy, 1);
        check_output("mid cap_clr", cap_clr, 1);
        seen_cap = 0;
        send_lines(3);
        vsync = 1; tick();
        repeat (3) tick();
        check_output("mid no partial capture", seen_cap, 0);
        check_output("mid still armed", busy, 1);
        vsync = 0; tick();
        check_output("single cap_en rise", cap_en, 1);
        send_lines(V_LN);
        close_frame("single", 1, 0);
        check_output("single px_cnt", px_cnt, H_PX * V_LN);
        check_output("single line_cnt", line_cnt, V_LN);
        check_output("single frame_cnt", frame_cnt, 1);
        check_output("single busy", busy, 0);
        tick();
        check_output("single pulse width", frame_done, 0);

        // ---------------- short frame ----------------
        start = 1; tick(); start = 0;
        tick();
        vsync = 0; tick();
        send_lines(V_LN - 1);
        close_frame("short", 0, 1);
        check_output("short px_cnt", px_cnt, H_PX * (V_LN - 1));
        check_output("short line_cnt", line_cnt, V_LN - 1);
        check_output("short frame_cnt", frame_cnt, 2);

        // ---------------- continuous with stop in frame 3 ----------------
        do_reset();
        mode_cont = 1;
        start = 1; tick(); start = 0;
        mode_cont = 0;
        for (int f = 1; f <= 2; f++) begin
            tick();
            vsync = 0; tick();
            send_lines(2);
            close_frame($sformatf("cont f%0d", f), 0, 1);
            check_output($sformatf("cont f%0d frame_cnt", f), frame_cnt, f);
            check_output($sformatf("cont f%0d rearm clr", f), cap_clr, 1);
            check_output($sformatf("cont f%0d busy", f), busy, 1);
        end
        tick();
        vsync = 0; tick();
        send_lines(60);
        stop = 1; tick(); stop = 0;
        check_output("cont stop keeps frame", cap_en, 1);
        send_lines(V_LN - 60);
        close_frame("cont f3", 1, 0);
        check_output("cont f3 frame_cnt", frame_cnt, 3);
        check_output("cont f3 busy", busy, 0);
        check_output("cont f3 no rearm clr", cap_clr, 0);
        tick();
        vsync = 0; tick();
        check_output("cont no rearm cap_en", cap_en, 0);
        check_output("cont no rearm busy", busy, 0);
        vsync = 1; tick();

        // ---------------- ARM timeout (TIMEOUT = 100) ----------------
        seen_cap_t = 0;
        start_to = 1; tick(); start_to = 0;
        n = 0;
        while (!frame_err_t && n < 300) begin
            tick();
            n++;
        end
        check_output("timeout err seen", frame_err_t, 1);
        check_output("timeout latency", n, 101);
        check_output("timeout no done", frame_done_t, 0);
        check_output("timeout no cap_en", seen_cap_t, 0);
        check_output("timeout frame_cnt", frame_cnt_t, 1);
        check_output("timeout busy", busy_t, 0);

        // ---------------- asynchronous reset during CAPTURE ----------------
        start = 1; tick(); start = 0;
        vsync = 0; tick();
        send_lines(3);
        check_output("arst pre px_cnt", px_cnt, 3 * H_PX);
        check_output("arst pre cap_en", cap_en, 1);
        seen_done = 0; seen_err = 0;
        #2;
        rst = 0;
        #1;
        check_output("arst cap_en", cap_en, 0);
        check_output("arst busy", busy, 0);
        check_output("arst px_cnt", px_cnt, 0);
        check_output("arst line_cnt", line_cnt, 0);
        check_output("arst frame_cnt", frame_cnt, 0);
        tick();
        rst = 1;
        vsync = 1;
        repeat (4) tick();
        check_output("arst no done", seen_done, 0);
        check_output("arst no err", seen_err, 0);
        check_output("arst idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run time in case the DUT wedges a loop
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/cam_capture_ctrl.md
# cam_capture_ctrl

Frame-capture sequencer for the OV7670 capture path. It arms the pixel-capture datapath (`cam_read`) on request and opens it only on a clean frame boundary. It counts the pixels and lines written to the framebuffer and reports each frame as done or erroneous. It sits between the top-level control logic (buttons/host) and `cam_read`, in the `pclk` domain.

## Interface
- `H_PX`, 160, pixels per line (written words per line)
- `V_LN`, 120, lines per frame
- `AW`, 15, framebuffer address width; must satisfy 2^AW ≥ H_PX·V_LN
- `TIMEOUT`, 2000000, `pclk` cycles allowed in ARM without a frame start
- `pclk`  in  1  camera pixel clock; only clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  capture request, level-sampled, one cycle is enough
- `stop`  in  1  abort/terminate request
- `mode_cont`  in  1  1 = continuous frames, 0 = single shot; sampled on accepted `start`
- `vsync`  in  1  camera VSYNC (high = vertical blank), already synchronous to `pclk`
- `href`  in  1  camera HREF
- `px_wr`  in  1  write strobe from `cam_read`
- `cap_en`  out  1  enables `cam_read` (drives its `inicio`)
- `cap_clr`  out  1  one-cycle clear pulse to `cam_read` address/counters
- `busy`  out  1  high in any state except IDLE
- `frame_done`  out  1  one-cycle pulse, frame closed with correct counts
- `frame_err`  out  1  one-cycle pulse, frame closed with wrong counts or timeout
- `px_cnt`  out  AW+1  `px_wr` strobes in the current/last frame, saturating
- `line_cnt`  out  8  `href` falling edges in the current/last frame, saturating at 255
- `frame_cnt`  out  8  completed frames (done or err), wraps 255→0

## Operation
- Edge detection: `vsync_q`, `href_q` registered; `vs_fall = vsync_q & ~vsync` is the frame start; `vs_rise = ~vsync_q & vsync` is the frame end; `hr_fall = href_q & ~href` is the line end.
- States:
  - IDLE: outputs low. `start & ~stop` → ARM; `cont` latched from `mode_cont`.
  - ARM: `cap_clr` pulses on entry; timeout counter runs.
    - `stop` → IDLE.
    - `vs_fall` → CAPTURE; clears `px_cnt` and `line_cnt`.
    - Timeout counter = TIMEOUT−1 → CLOSE with error.
  - CAPTURE: `cap_en`=1; `px_cnt` increments on `px_wr`; `line_cnt` increments on `hr_fall`.
    - `stop` clears `cont` but does not end the frame.
    - `vs_rise` → CLOSE.
  - CLOSE: one cycle, `cap_en`=0.
    - Pulses `frame_done` if `px_cnt`==H_PX·V_LN and `line_cnt`==V_LN, else `frame_err`.
    - Increments `frame_cnt`.
    - Then → ARM if `cont`, else IDLE.
- A `start` arriving mid-frame never captures a partial frame. ARM waits for the next `vs_fall`.
- `start` in any state other than IDLE is ignored. `start` and `stop` in the same cycle: `stop` wins.
- `px_cnt` and `line_cnt` hold their values after CLOSE until the next `vs_fall` in ARM.
- `px_wr` outside CAPTURE is ignored.

## Timing
- Reset: state IDLE; all outputs 0; `vsync_q`=1, `href_q`=0; `cont`=0; timeout counter 0.
- `cap_en` rises 1 cycle after the cycle in which `vs_fall` is seen, and falls 1 cycle after `vs_rise` is seen.
- `frame_done`/`frame_err` are asserted exactly 2 cycles after `vs_rise` is seen (one cycle into CLOSE's output), always 1 cycle wide and mutually exclusive.
- `cap_clr` is high in the first cycle after entering ARM, both from IDLE and from CLOSE.
- `px_wr` coincident with `vs_rise` is counted. `hr_fall` coincident with `vs_rise` is counted.
- Reset mid-frame: immediate return to IDLE and `cap_en`=0. No done/err pulse.

## Structure
- Package `cam_pkg`: state enum (IDLE, ARM, CAPTURE, CLOSE), default `H_PX`/`V_LN`, constant `FRAME_PX = H_PX*V_LN`.
- Sub-module `edge_det` (register plus rise/fall outputs, parameterised reset value), instantiated for `vsync` and `href`.
- FSM, counters and timeout live in `cam_capture_ctrl`.

## Test plan
- Single shot: `mode_cont`=0, `start`, then a 120-line × 160-`px_wr` frame → one `frame_done` 2 cycles after `vs_rise`; `px_cnt`=19200, `line_cnt`=120, `frame_cnt`=1; then IDLE, `busy`=0.
- Mid-frame start: `start` while `vsync`=0 with lines in progress → no `cap_en` until the next `vs_fall`; the following full frame reports `frame_done`.
- Short frame: 119 lines delivered → `frame_err`, `line_cnt`=119, `px_cnt`=19040.
- Continuous plus stop: `mode_cont`=1, 3 frames then `stop` during frame 3 → frame 3 completes with `frame_done`; `frame_cnt`=3; IDLE, no re-arm.
- Timeout: `TIMEOUT`=100, `vsync` held high → `frame_err` when the timeout counter reaches 99; `cap_en` never asserted.
- Async reset asserted during CAPTURE → `cap_en`, `busy` and the counters go to 0 without waiting for `pclk`; no done/err pulse.
